gam_pattern_sequencer: RTL
==========================

// Module: gam_pattern_sequencer
// PURPOSE
//  Synthesizable training and recall stimulus sequencer for the GAM Memory_Layer.
//  Stores up to CLASS_MAX x NODE_MAX node vectors. Issues them class by class on the
//  Memory_Layer ready_wait handshake, raises learning_done, then switches
//  learning_recall to RECALL and presents recall patterns.
//  Sits between the host/load port and Memory_Layer + auto_associative_recall.
// PARAMETERS
//  W          32                   node vector width (node_vector_T)
//  CLASS_MAX  4                    max classes stored; classes indexed 1..CLASS_MAX
//  NODE_MAX   16                   max nodes per class; nodes indexed 1..NODE_MAX
//  CW         $clog2(CLASS_MAX+1)  class index width (derived)
//  NW         $clog2(NODE_MAX+1)   node index width (derived)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous active-high reset
//  ld_we          in   1   write ld_data to pattern store at [ld_class][ld_node]
//  ld_class       in   CW  load class index, 1..CLASS_MAX
//  ld_node        in   NW  load node index, 1..NODE_MAX
//  ld_data        in   W   load pattern
//  cfg_classes    in   CW  classes to issue, 1..CLASS_MAX; sampled on start
//  cfg_nodes      in   NW  nodes per class, 1..NODE_MAX; sampled on start
//  start          in   1   pulse: begin learning pass
//  recall_req     in   1   pulse: present recall_x in RECALL mode
//  recall_x       in   W   recall probe pattern
//  ready_wait     in   1   from Memory_Layer; 1=READY, 0=WAIT
//  x              out  W   node vector to Memory_Layer / recall
//  c              out  CW  class of x
//  learning_recall out 1   0=LEARNING, 1=RECALL
//  learning_done  out  1   all configured patterns issued
//  x_valid        out  1   1-cycle pulse per newly driven x
//  busy           out  1   high in ISSUE
//  err            out  1   sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; x=0, c=0, learning_recall=0, learning_done=0, x_valid=0,
//   busy=0, err=0; cls=1, node=1, armed=1. Pattern store is NOT cleared.
//   Reset mid-pass aborts the pass; the next cycle is IDLE.
//  States: IDLE, ISSUE, DONE, RECALL. All outputs are registered.
//  Load: ld_we is accepted in IDLE/DONE/RECALL. Index 0 or > max is dropped and sets err.
//   ld_we in ISSUE is dropped and sets err.
//  IDLE/DONE/RECALL + start:
//   - cfg in range: latch cfg, cls=1, node=1, armed=1, learning_done=0,
//     learning_recall=0, go ISSUE.
//   - cfg 0 or > max: set err, state unchanged.
//  ISSUE: busy=1. Issue when ready_wait==1 && armed:
//   - next cycle x=mem[cls][node], c=cls, x_valid=1; armed<=0.
//   - Latency is 1 clk from the ready sample.
//   - armed<=1 on any cycle ready_wait==0 is sampled. READY held high therefore issues
//     exactly one pattern; each further pattern needs a WAIT->READY transition.
//   - Advance: node++; when node==cfg_nodes, node=1 and cls++.
//   - Issuing [cfg_classes][cfg_nodes] -> DONE; learning_done=1 in the same cycle as
//     that x_valid.
//  DONE: busy=0; x/c hold the last issued pattern; learning_done=1.
//   recall_req -> RECALL.
//  RECALL: learning_recall=1. Each recall_req drives x=recall_x, c=0, x_valid=1 next cycle.
//   learning_done stays 1.
//  start and recall_req in the same cycle: start wins. recall_req outside DONE/RECALL
//   is ignored.
//  start during ISSUE is ignored (no restart).
// CONFIGURATION
//  GAM_SEQ_ZERO_CHECK_EN defined:
//   - In ISSUE, an all-zero stored pattern is skipped: no x_valid, armed is unaffected,
//     err set, index advances one entry per cycle.
//   - If the skipped entry is the last one, go DONE (learning_done=1, no x_valid).
//   - recall_x==0 on recall_req sets err and is not driven.
//  Not defined: zero patterns are issued like any other; err is never set by data value.
// TESTING
//  1. Load class1 nodes 1..8 (03,0400,070005,0101,0c0b0a09,0604,060002,0202);
//     cfg 1/8; start; toggle ready each 4 clk
//     -> 8 x_valid pulses, c=1, x in load order; learning_done=1 with 8th pulse.
//  2. ready_wait held 1 for 20 clk after start -> exactly one x_valid (x=03);
//     drop ready 1 clk -> x=0400 issued 2 clk later.
//  3. After test 1, recall_req with recall_x=070005 -> learning_recall=1,
//     x=070005, x_valid 1 clk later; start+recall_req same cycle -> ISSUE, learning_recall=0.
//  4. cfg 3 classes x 2 nodes
//     -> issue order (1,1)(1,2)(2,1)(2,2)(3,1)(3,2); cfg_classes=0 -> err=1, stays IDLE.
//  5. Reset asserted after 3rd issue -> next clk all outputs 0, IDLE;
//     restart re-issues from (1,1) with previously loaded data.
//  6. GAM_SEQ_ZERO_CHECK_EN: node 2 zero, cfg 1/3 -> x_valid for nodes 1,3 only,
//     err=1; without macro -> 3 pulses, x=0 on 2nd.

Source files
------------

// File: rtl/gam_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// gam_pattern_sequencer
//
// Training and recall stimulus sequencer for the GAM Memory_Layer. Holds up to
// CLASS_MAX x NODE_MAX node vectors loaded from a host port, issues them class
// by class on the Memory_Layer ready_wait handshake, raises learning_done when
// the configured set has been issued, and then presents host recall probes in
// RECALL mode.
//
// Optional feature: define GAM_SEQ_ZERO_CHECK_EN to skip all-zero stored
// patterns during ISSUE and to reject all-zero recall probes (both set err).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ld_we/ld_class/ld_node/ld_data   pattern store write port (1-based indices)
//   cfg_classes/cfg_nodes            pass size, sampled on start
//   start             pulse, begin a learning pass
//   recall_req/recall_x              recall probe request and pattern
//   ready_wait        Memory_Layer handshake, 1=READY 0=WAIT
//   x, c              issued node vector and its class (c=0 for recall probes)
//   learning_recall   0=LEARNING, 1=RECALL
//   learning_done     all configured patterns issued
//   x_valid           one-cycle pulse per newly driven x
//   busy              high while issuing
//   err               sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module gam_pattern_sequencer #(
  parameter int W         = 32,
  parameter int CLASS_MAX = 4,
  parameter int NODE_MAX  = 16,
  parameter int CW        = $clog2(CLASS_MAX + 1),
  parameter int NW        = $clog2(NODE_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_we,
  input  logic [CW-1:0] ld_class,
  input  logic [NW-1:0] ld_node,
  input  logic [W-1:0]  ld_data,
  input  logic [CW-1:0] cfg_classes,
  input  logic [NW-1:0] cfg_nodes,
  input  logic          start,
  input  logic          recall_req,
  input  logic [W-1:0]  recall_x,
  input  logic          ready_wait,
  output logic [W-1:0]  x,
  output logic [CW-1:0] c,
  output logic          learning_recall,
  output logic          learning_done,
  output logic          x_valid,
  output logic          busy,
  output logic          err
);

  localparam int DEPTH = CLASS_MAX * NODE_MAX;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CLS_MAX_V  = CW'(CLASS_MAX);
  localparam logic [NW-1:0] NODE_MAX_V = NW'(NODE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, RECALL} state_t;

  function automatic logic cls_ok(input logic [CW-1:0] v);
    return (v != '0) && (v <= CLS_MAX_V);
  endfunction

  function automatic logic node_ok(input logic [NW-1:0] v);
    return (v != '0) && (v <= NODE_MAX_V);
  endfunction

  // Indices are 1-based; the store is a flat class-major array.
  function automatic logic [AW-1:0] entry_addr(input logic [CW-1:0] cl,
                                               input logic [NW-1:0] nd);
    int a;
    a = (int'(cl) - 1) * NODE_MAX + (int'(nd) - 1);
    return AW'(a);
  endfunction

  logic [W-1:0] mem [DEPTH];

  state_t        state, state_n;
  logic [CW-1:0] cls, cls_n;
  logic [NW-1:0] node, node_n;
  logic          armed, armed_n;
  logic [CW-1:0] cfg_cls_q, cfg_cls_n;
  logic [NW-1:0] cfg_nodes_q, cfg_nodes_n;

  logic [W-1:0]  x_n;
  logic [CW-1:0] c_n;
  logic          lr_n, ld_n, xv_n, busy_n, err_n;
  logic          mem_we;
  logic          adv;
  logic          last;
  logic [W-1:0]  rd_data;

  always_comb begin
    state_n     = state;
    cls_n       = cls;
    node_n      = node;
    armed_n     = armed;
    cfg_cls_n   = cfg_cls_q;
    cfg_nodes_n = cfg_nodes_q;
    x_n         = x;
    c_n         = c;
    lr_n        = learning_recall;
    ld_n        = learning_done;
    xv_n        = 1'b0;
    busy_n      = busy;
    err_n       = err;
    mem_we      = 1'b0;
    adv         = 1'b0;
    rd_data     = mem[entry_addr(cls, node)];
    last        = (cls == cfg_cls_q) && (node == cfg_nodes_q);

    // A sampled WAIT re-arms the handshake, so READY held high issues once.
    if (!ready_wait) armed_n = 1'b1;

    if (ld_we) begin
      if (state == ISSUE || !cls_ok(ld_class) || !node_ok(ld_node)) err_n = 1'b1;
      else                                                          mem_we = 1'b1;
    end

    case (state)
      ISSUE: begin
`ifdef GAM_SEQ_ZERO_CHECK_EN
        if (rd_data == '0) begin
          err_n = 1'b1;
          adv   = 1'b1;
        end else
`endif
        if (ready_wait && armed) begin
          x_n     = rd_data;
          c_n     = cls;
          xv_n    = 1'b1;
          armed_n = 1'b0;
          adv     = 1'b1;
        end
      end
      default: begin
        // start has priority over recall_req.
        if (start) begin
          if (cls_ok(cfg_classes) && node_ok(cfg_nodes)) begin
            cfg_cls_n   = cfg_classes;
            cfg_nodes_n = cfg_nodes;
            cls_n       = CW'(1);
            node_n      = NW'(1);
            armed_n     = 1'b1;
            ld_n        = 1'b0;
            lr_n        = 1'b0;
            busy_n      = 1'b1;
            state_n     = ISSUE;
          end else begin
            err_n = 1'b1;
          end
        end else if (recall_req && (state == DONE || state == RECALL)) begin
          state_n = RECALL;
          lr_n    = 1'b1;
`ifdef GAM_SEQ_ZERO_CHECK_EN
          if (recall_x == '0) begin
            err_n = 1'b1;
          end else begin
            x_n  = recall_x;
            c_n  = '0;
            xv_n = 1'b1;
          end
`else
          x_n  = recall_x;
          c_n  = '0;
          xv_n = 1'b1;
`endif
        end
      end
    endcase

    // Step to the next store entry; the final entry ends the pass.
    if (adv) begin
      if (last) begin
        state_n = DONE;
        busy_n  = 1'b0;
        ld_n    = 1'b1;
      end else if (node == cfg_nodes_q) begin
        node_n = NW'(1);
        cls_n  = cls + CW'(1);
      end else begin
        node_n = node + NW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cls             <= CW'(1);
      node            <= NW'(1);
      armed           <= 1'b1;
      x               <= '0;
      c               <= '0;
      learning_recall <= 1'b0;
      learning_done   <= 1'b0;
      x_valid         <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_n;
      cls             <= cls_n;
      node            <= node_n;
      armed           <= armed_n;
      x               <= x_n;
      c               <= c_n;
      learning_recall <= lr_n;
      learning_done   <= ld_n;
      x_valid         <= xv_n;
      busy            <= busy_n;
      err             <= err_n;
    end
  end

  // Pass configuration and pattern store are data: not reset.
  always_ff @(posedge clk) begin
    cfg_cls_q   <= cfg_cls_n;
    cfg_nodes_q <= cfg_nodes_n;
    if (mem_we) mem[entry_addr(ld_class, ld_node)] <= ld_data;
  end

endmodule
